adc_pixel_packer: RTL and testbench
===================================

# adc_pixel_packer

Downstream neighbour of the ADC capture stage, in the `hw_pixel_clk` domain. Takes the per-cycle pixel stream (RGB565 data plus x/y position) and discards blanking pixels. Packs horizontally adjacent active pixels into 32-bit words, each with a linear frame-buffer word address. Presents the words to the frame-buffer write FIFO over a valid/ready handshake and flags frame boundaries and stream faults.

## Interface
- `X_RES`, 800, active pixels per line; must be even.
- `Y_RES`, 600, active lines per frame.
- `ADDR_WIDTH`, 18, word-address width; must satisfy 2^ADDR_WIDTH ≥ X_RES*Y_RES/2.
- `hw_pixel_clk`  in  1  pixel clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  pixel qualifier; capture stage drives it high every cycle.
- `in_data`  in  16  RGB565 pixel.
- `in_x`  in  11  pixel column.
- `in_y`  in  11  pixel row.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  FIFO accepts the word (write when both are high).
- `out_data`  out  32  {odd pixel, even pixel}; even pixel in [15:0].
- `out_addr`  out  ADDR_WIDTH  word address = y*(X_RES/2) + x/2.
- `out_frame_start`  out  1  high with the word at address 0.
- `frame_done`  out  1  one-cycle pulse after the last word of a frame.
- `locked`  out  1  high while in ACTIVE state.
- `overflow_count`  out  16  saturating count of dropped words.
- `resync_count`  out  16  saturating count of sequence faults.

## Operation
- **Active pixel:** `in_valid` && `in_x` < X_RES && `in_y` < Y_RES. All other inputs are ignored, including pixels with `in_valid` low.
- **States: WAIT_FRAME (reset state)**
  - Ignores every active pixel except (0,0).
  - On (0,0): store it as the even half, set expected coordinate to (1,0), go to ACTIVE.
- **States: ACTIVE**
  - Each active pixel must equal the expected coordinate; expected then advances in raster order (x wraps at X_RES, y increments).
  - Even x: latch `in_data` into the half-word register.
  - Odd x: form the word {in_data, half} with address = internal word counter; the counter increments by one per formed word.
  - After the word at address X_RES*Y_RES/2-1 is formed: pulse `frame_done`, go to WAIT_FRAME.
  - An active pixel that is not the expected coordinate is a fault: discard the half word, increment `resync_count`, go to WAIT_FRAME.
  - A faulting pixel at (0,0) is re-evaluated in WAIT_FRAME on the same cycle, so it locks immediately.
- **Output register (single entry)**
  - A formed word loads it when the register is empty, or when it is full and `out_ready` is high that cycle (word replaced, no loss).
  - If the register is full and `out_ready` is low, the new word is dropped; the held word is kept unchanged and `overflow_count` increments.
  - The word counter still advances on a drop, so later addresses stay correct.
  - While `out_valid` is high and `out_ready` is low, `out_data`, `out_addr` and `out_frame_start` hold stable.
- **Counters:** both saturate at 16'hFFFF.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_addr` 0, `out_frame_start` 0, `frame_done` 0, `locked` 0, both counts 0. All internal state clears and the FSM returns to WAIT_FRAME.
- **Latency:** odd pixel sampled at edge N → `out_valid` high after edge N (visible in cycle N+1).
- `frame_done` is asserted in the same cycle as the final word's `out_valid`, regardless of `out_ready`.
- `locked` rises the cycle after the (0,0) pixel and falls the cycle after the final word or a fault.
- Reset mid-frame: the pending word is lost without a drop count. The block relocks on the next (0,0).

## Configuration
- **`ADC_PACKER_STATS_EN` defined:** `overflow_count` and `resync_count` operate as described.
- **`ADC_PACKER_STATS_EN` not defined:** both ports are tied to 0 and the counter logic is absent. Dropping and resync behaviour are unchanged.

## Test plan
- Full 800x600 raster with `out_ready`=1, lock at (0,0):
  - 240000 words, addresses 0..239999 in order.
  - Word 0 = {pix(1,0), pix(0,0)} with `out_frame_start`=1.
  - `frame_done` pulses once, with address 239999.
- Start the stream mid-frame at (400,300): no output until the next (0,0); `locked` stays 0 until then.
- Hold `out_ready`=0 across 3 formed words:
  - First word held stable.
  - 2 drops, `overflow_count`=2.
  - After release, the next word carries address first+3.
- Skip pixel (10,5) (jump from (9,5) to (11,5)):
  - `resync_count`=1, `locked` drops.
  - No words after address 5*400+4 until the next frame.
- Blanking inputs (x=900, or y=610) and `in_valid`=0 cycles inserted mid-line: ignored, with identical output to the clean run.
- Assert `rst_n` low for 1 cycle mid-line: all outputs 0 immediately; the next (0,0) relocks and addresses restart at 0.

Source files
------------

// File: rtl/adc_pixel_packer.sv
// adc_pixel_packer: packs horizontally adjacent active RGB565 pixels into 32-bit
// frame-buffer words with linear word addresses. Discards blanking pixels. Presents
// the words through a single-entry valid/ready output register.
//
// Parameters: X_RES (even) / Y_RES active resolution, ADDR_WIDTH word-address width.
// Ports:
//   hw_pixel_clk, rst_n        clock, async active-low reset
//   in_valid/in_data/in_x/in_y pixel stream from the capture stage
//   out_valid/out_ready        word handshake towards the frame-buffer FIFO
//   out_data                   {odd pixel, even pixel}
//   out_addr                   word address y*(X_RES/2) + x/2
//   out_frame_start            marks the word at address 0
//   frame_done                 one-cycle pulse with the frame's final word
//   locked                     high while tracking a frame
//   overflow_count             saturating count of dropped words
//   resync_count               saturating count of sequence faults
// Build option: ADC_PACKER_STATS_EN enables the two counters; when it is not
// defined, both counter ports read 0.
module adc_pixel_packer #(
    parameter int unsigned X_RES      = 800,
    parameter int unsigned Y_RES      = 600,
    parameter int unsigned ADDR_WIDTH = 18
) (
    input  logic                  hw_pixel_clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [15:0]           in_data,
    input  logic [10:0]           in_x,
    input  logic [10:0]           in_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_frame_start,
    output logic                  frame_done,
    output logic                  locked,
    output logic [15:0]           overflow_count,
    output logic [15:0]           resync_count
);

    localparam int unsigned           COORD_W   = 11;
    localparam int unsigned           WORDS     = X_RES * Y_RES / 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);
    localparam logic [COORD_W-1:0]    X_LAST    = COORD_W'(X_RES - 1);

    typedef enum logic [0:0] {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } state_t;

    state_t                state, state_n;
    logic [COORD_W-1:0]    exp_x, exp_x_n;
    logic [COORD_W-1:0]    exp_y, exp_y_n;
    logic [15:0]           half, half_n;
    logic [ADDR_WIDTH-1:0] word_cnt, word_cnt_n;

    logic                  out_valid_n;
    logic [31:0]           out_data_n;
    logic [ADDR_WIDTH-1:0] out_addr_n;
    logic                  out_frame_start_n;
    logic                  frame_done_n;
    logic                  locked_n;

    logic                  active;
    logic                  origin;
    logic                  match;
    logic                  word_form;
    logic                  last_word;
    logic                  relock;

    // Pixel classification
    assign active = in_valid && (32'(in_x) < X_RES) && (32'(in_y) < Y_RES);
    assign origin = active && (in_x == '0) && (in_y == '0);
    assign match  = active && (in_x == exp_x) && (in_y == exp_y);

    // Next-state, sequencing and output-register logic
    always_comb begin
        state_n           = state;
        exp_x_n           = exp_x;
        exp_y_n           = exp_y;
        half_n            = half;
        word_cnt_n        = word_cnt;
        word_form         = 1'b0;
        last_word         = 1'b0;
        relock            = 1'b0;
        out_valid_n       = out_valid;
        out_data_n        = out_data;
        out_addr_n        = out_addr;
        out_frame_start_n = out_frame_start;

        case (state)
            WAIT_FRAME: begin
                relock = origin;
            end
            ACTIVE: begin
                if (active) begin
                    if (match) begin
                        if (exp_x == X_LAST) begin
                            exp_x_n = '0;
                            exp_y_n = exp_y + COORD_W'(1);
                        end else begin
                            exp_x_n = exp_x + COORD_W'(1);
                        end
                        if (!in_x[0]) begin
                            half_n = in_data;
                        end else begin
                            word_form  = 1'b1;
                            word_cnt_n = word_cnt + ADDR_WIDTH'(1);
                            if (word_cnt == LAST_ADDR) begin
                                last_word = 1'b1;
                                state_n   = WAIT_FRAME;
                            end
                        end
                    end else begin
                        // Sequence fault; a faulting (0,0) relocks on the same edge
                        state_n = WAIT_FRAME;
                        relock  = origin;
                    end
                end
            end
            default: begin
                state_n = WAIT_FRAME;
            end
        endcase

        if (relock) begin
            state_n    = ACTIVE;
            half_n     = in_data;
            exp_x_n    = COORD_W'(1);
            exp_y_n    = '0;
            word_cnt_n = '0;
        end

        // Single-entry output register: a new word may replace one being accepted
        if (out_valid && out_ready) begin
            out_valid_n = 1'b0;
        end
        if (word_form && (!out_valid || out_ready)) begin
            out_valid_n       = 1'b1;
            out_data_n        = {in_data, half};
            out_addr_n        = word_cnt;
            out_frame_start_n = (word_cnt == '0);
        end

        frame_done_n = last_word;
        locked_n     = (state_n == ACTIVE);
    end

    // State and output registers
    always_ff @(posedge hw_pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= WAIT_FRAME;
            exp_x           <= '0;
            exp_y           <= '0;
            half            <= '0;
            word_cnt        <= '0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_addr        <= '0;
            out_frame_start <= 1'b0;
            frame_done      <= 1'b0;
            locked          <= 1'b0;
        end else begin
            state           <= state_n;
            exp_x           <= exp_x_n;
            exp_y           <= exp_y_n;
            half            <= half_n;
            word_cnt        <= word_cnt_n;
            out_valid       <= out_valid_n;
            out_data        <= out_data_n;
            out_addr        <= out_addr_n;
            out_frame_start <= out_frame_start_n;
            frame_done      <= frame_done_n;
            locked          <= locked_n;
        end
    end

`ifdef ADC_PACKER_STATS_EN
    logic fault;
    logic drop;

    assign fault = (state == ACTIVE) && active && !match;
    assign drop  = word_form && out_valid && !out_ready;

    // Saturating statistics counters
    always_ff @(posedge hw_pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_count <= '0;
            resync_count   <= '0;
        end else begin
            if (drop && (overflow_count != 16'hFFFF)) begin
                overflow_count <= overflow_count + 16'd1;
            end
            if (fault && (resync_count != 16'hFFFF)) begin
                resync_count <= resync_count + 16'd1;
            end
        end
    end
`else
    assign overflow_count = '0;
    assign resync_count   = '0;
`endif

endmodule

// File: tb/tb_adc_pixel_packer.sv
// tb_adc_pixel_packer: directed bench for adc_pixel_packer on a reduced 16x8
// raster (64 words per frame). Pixel data is a unique function of (x,y).
// Counter expectations follow the ADC_PACKER_STATS_EN build option.
module tb_adc_pixel_packer;

    localparam int XR    = 16;
    localparam int YR    = 8;
    localparam int AW    = 8;
    localparam int WORDS = XR * YR / 2;

`ifdef ADC_PACKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [15:0]   in_data;
    logic [10:0]   in_x;
    logic [10:0]   in_y;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [AW-1:0] out_addr;
    logic          out_frame_start;
    logic          frame_done;
    logic          locked;
    logic [15:0]   overflow_count;
    logic [15:0]   resync_count;

    int vectors     = 0;
    int miscompares = 0;

    adc_pixel_packer #(
        .X_RES      (XR),
        .Y_RES      (YR),
        .ADDR_WIDTH (AW)
    ) dut (
        .hw_pixel_clk    (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_x            (in_x),
        .in_y            (in_y),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_addr        (out_addr),
        .out_frame_start (out_frame_start),
        .frame_done      (frame_done),
        .locked          (locked),
        .overflow_count  (overflow_count),
        .resync_count    (resync_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pd(input int x, input int y);
        return 16'(x * 157 + y * 4099 + 16'h5A3C);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one input cycle, then sample 1 ns after the edge
    task automatic drive(input logic v, input int x, input int y, input logic [15:0] d);
        in_valid = v;
        in_x     = 11'(x);
        in_y     = 11'(y);
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic px(input int x, input int y);
        drive(1'b1, x, y, pd(x, y));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 0);
        chk({tag, "_data"}, 64'(out_data), 0);
        chk({tag, "_addr"}, 64'(out_addr), 0);
        chk({tag, "_fstart"}, 64'(out_frame_start), 0);
        chk({tag, "_fdone"}, 64'(frame_done), 0);
        chk({tag, "_locked"}, 64'(locked), 0);
        chk({tag, "_ovf"}, 64'(overflow_count), 0);
        chk({tag, "_resync"}, 64'(resync_count), 0);
    endtask

    // Blanking and invalid cycles, some carrying coordinates that would be
    // accepted if the qualifier or the range checks were ignored
    task automatic blank_cycles(input int y);
        drive(1'b0, 0, 0, 16'hDEAD);
        chk("blank_locked0", 64'(locked), 1);
        drive(1'b1, 900, y, 16'hBEEF);
        chk("blank_locked1", 64'(locked), 1);
        drive(1'b1, 5, 610, 16'hCAFE);
        chk("blank_locked2", 64'(locked), 1);
        drive(1'b0, 5, y, 16'h1111);
        chk("blank_valid", 64'(out_valid), 0);
    endtask

    // Whole frame from (0,0) with out_ready high, every cycle checked
    task automatic run_frame(input bit blank);
        int addr;
        for (int y = 0; y < YR; y++) begin
            for (int x = 0; x < XR; x++) begin
                px(x, y);
                if (x == 0 && y == 0) chk("lock", 64'(locked), 1);
                if (x % 2 == 1) begin
                    addr = y * (XR / 2) + x / 2;
                    chk("w_valid", 64'(out_valid), 1);
                    chk("w_addr", 64'(out_addr), 64'(addr));
                    chk("w_data", 64'(out_data), 64'({pd(x, y), pd(x - 1, y)}));
                    chk("w_fstart", 64'(out_frame_start), 64'(addr == 0));
                    chk("w_fdone", 64'(frame_done), 64'(addr == WORDS - 1));
                end else begin
                    chk("gap_valid", 64'(out_valid), 0);
                    chk("gap_fdone", 64'(frame_done), 0);
                end
                if (blank && x == 4) blank_cycles(y);
            end
        end
        chk("unlock_end", 64'(locked), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;

        // Stream starting mid-frame: nothing happens until the next (0,0)
        for (int p = 4 * XR + 8; p < XR * YR; p++) begin
            px(p % XR, p / XR);
            chk("mid_valid", 64'(out_valid), 0);
            chk("mid_locked", 64'(locked), 0);
        end

        run_frame(1'b0);
        run_frame(1'b1);

        // Backpressure across three formed words
        px(0, 0);
        out_ready = 1'b0;
        px(1, 0);
        chk("bp_w0_valid", 64'(out_valid), 1);
        chk("bp_w0_addr", 64'(out_addr), 0);
        px(2, 0);
        px(3, 0);
        chk("bp_hold1_data", 64'(out_data), 64'({pd(1, 0), pd(0, 0)}));
        chk("bp_hold1_addr", 64'(out_addr), 0);
        px(4, 0);
        px(5, 0);
        chk("bp_hold2_valid", 64'(out_valid), 1);
        chk("bp_hold2_data", 64'(out_data), 64'({pd(1, 0), pd(0, 0)}));
        chk("bp_hold2_addr", 64'(out_addr), 0);
        chk("bp_hold2_fstart", 64'(out_frame_start), 1);
        chk("bp_ovf", 64'(overflow_count), STATS ? 64'd2 : 64'd0);
        out_ready = 1'b1;
        px(6, 0);
        chk("bp_release_valid", 64'(out_valid), 0);
        px(7, 0);
        chk("bp_next_valid", 64'(out_valid), 1);
        chk("bp_next_addr", 64'(out_addr), 3);
        chk("bp_next_data", 64'(out_data), 64'({pd(7, 0), pd(6, 0)}));
        for (int p = 8; p < XR * YR; p++) px(p % XR, p / XR);
        chk("bp_fdone", 64'(frame_done), 1);
        chk("bp_fdone_addr", 64'(out_addr), WORDS - 1);
        chk("bp_unlock", 64'(locked), 0);

        // Skip pixel (10,5)
        for (int p = 0; p <= 5 * XR + 9; p++) px(p % XR, p / XR);
        chk("skip_last_valid", 64'(out_valid), 1);
        chk("skip_last_addr", 64'(out_addr), 5 * (XR / 2) + 4);
        chk("skip_last_data", 64'(out_data), 64'({pd(9, 5), pd(8, 5)}));
        px(11, 5);
        chk("skip_locked", 64'(locked), 0);
        chk("skip_resync", 64'(resync_count), STATS ? 64'd1 : 64'd0);
        chk("skip_valid", 64'(out_valid), 0);
        for (int p = 5 * XR + 12; p < XR * YR; p++) begin
            px(p % XR, p / XR);
            chk("skip_rest_valid", 64'(out_valid), 0);
            chk("skip_rest_fdone", 64'(frame_done), 0);
        end
        chk("skip_ovf_kept", 64'(overflow_count), STATS ? 64'd2 : 64'd0);

        // A faulting (0,0) relocks on the same cycle
        px(0, 0);
        px(1, 0);
        chk("rl_first_addr", 64'(out_addr), 0);
        px(0, 0);
        chk("rl_locked", 64'(locked), 1);
        chk("rl_resync", 64'(resync_count), STATS ? 64'd2 : 64'd0);
        chk("rl_gap_valid", 64'(out_valid), 0);
        px(1, 0);
        chk("rl_valid", 64'(out_valid), 1);
        chk("rl_addr", 64'(out_addr), 0);
        chk("rl_fstart", 64'(out_frame_start), 1);
        chk("rl_data", 64'(out_data), 64'({pd(1, 0), pd(0, 0)}));
        px(2, 0);
        px(3, 0);
        chk("rl_w1_addr", 64'(out_addr), 1);

        // One-cycle asynchronous reset mid-line
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        chk_reset("mrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(1'b0);
        chk("post_rst_ovf", 64'(overflow_count), 0);
        chk("post_rst_resync", 64'(resync_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
